// File: rtl/io_interconnect_if.sv
// rtl/io_interconnect_if.sv - CPU request/response and shared MMIO slave bus bundle
interface io_interconnect_if #(
  parameter int NUM_SLAVES = 4
);
  logic                    cpu_req_valid;
  logic                    cpu_req_ready;
  logic                    cpu_req_wr;
  logic [31:0]             cpu_req_addr;
  logic [31:0]             cpu_req_wr_data;
  logic                    cpu_rsp_valid;
  logic [31:0]             cpu_rsp_rd_data;
  logic                    cpu_rsp_err;
  logic                    io_bus_s_rd_en;
  logic                    io_bus_s_wr_en;
  logic [31:0]             io_bus_s_address;
  logic [31:0]             io_bus_s_wr_data;
  logic [32*NUM_SLAVES-1:0] io_bus_s_rd_data;
  logic [NUM_SLAVES-1:0]   io_bus_s_rd_valid;

  // master: the bridge itself; slave: the CPU and peripherals around it
  modport master (
    input  cpu_req_valid, cpu_req_wr, cpu_req_addr, cpu_req_wr_data,
    input  io_bus_s_rd_data, io_bus_s_rd_valid,
    output cpu_req_ready, cpu_rsp_valid, cpu_rsp_rd_data, cpu_rsp_err,
    output io_bus_s_rd_en, io_bus_s_wr_en, io_bus_s_address, io_bus_s_wr_data
  );

  modport slave (
    output cpu_req_valid, cpu_req_wr, cpu_req_addr, cpu_req_wr_data,
    output io_bus_s_rd_data, io_bus_s_rd_valid,
    input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_rd_data, cpu_rsp_err,
    input  io_bus_s_rd_en, io_bus_s_wr_en, io_bus_s_address, io_bus_s_wr_data
  );
endinterface

// File: rtl/io_interconnect.sv
// rtl/io_interconnect.sv - single-master IO bridge broadcasting one request at a time to MMIO slaves
module io_interconnect #(
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  io_interconnect_if.master bus
);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // counter is cleared in ISSUE and bumped every WAIT cycle, so the last WAIT sees TIMEOUT_CYCLES-2
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_nx;
  logic          lat_wr, lat_wr_nx;
  logic [31:0]   lat_addr, lat_addr_nx;
  logic [31:0]   lat_wdata, lat_wdata_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [31:0]   rsp_data, rsp_data_nx;
  logic          rsp_err, rsp_err_nx;

  logic [31:0]   cap_data;
  logic          cap_any;
  logic          cap_multi;

  always_comb begin
    cap_data  = '0;
    cap_any   = 1'b0;
    cap_multi = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      cap_data  = cap_data | (bus.io_bus_s_rd_data[32*i +: 32] & {32{bus.io_bus_s_rd_valid[i]}});
      cap_multi = cap_multi | (cap_any & bus.io_bus_s_rd_valid[i]);
      cap_any   = cap_any | bus.io_bus_s_rd_valid[i];
    end
  end

  always_comb begin
    state_nx     = state;
    lat_wr_nx    = lat_wr;
    lat_addr_nx  = lat_addr;
    lat_wdata_nx = lat_wdata;
    cnt_nx       = cnt;
    rsp_data_nx  = rsp_data;
    rsp_err_nx   = rsp_err;
    case (state)
      IDLE: begin
        if (bus.cpu_req_valid) begin
          lat_wr_nx    = bus.cpu_req_wr;
          lat_addr_nx  = bus.cpu_req_addr;
          lat_wdata_nx = bus.cpu_req_wr_data;
          state_nx     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nx = '0;
        if (lat_wr) begin
          rsp_data_nx = '0;
          rsp_err_nx  = 1'b0;
          state_nx    = RESP;
        end else if (cap_any) begin
          rsp_data_nx = cap_data;
          rsp_err_nx  = cap_multi;
          state_nx    = RESP;
        end else begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        cnt_nx = cnt + 1'b1;
        if (cap_any) begin
          rsp_data_nx = cap_data;
          rsp_err_nx  = cap_multi;
          state_nx    = RESP;
        end else if (cnt == CNT_LAST) begin
          rsp_data_nx = '0;
          rsp_err_nx  = 1'b1;
          state_nx    = RESP;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt       <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      lat_wr    <= lat_wr_nx;
      lat_addr  <= lat_addr_nx;
      lat_wdata <= lat_wdata_nx;
      cnt       <= cnt_nx;
      rsp_data  <= rsp_data_nx;
      rsp_err   <= rsp_err_nx;
    end
  end

  // bus outputs decode from state so an async reset drops strobes immediately
  assign bus.cpu_req_ready    = (state == IDLE);
  assign bus.cpu_rsp_valid    = (state == RESP);
  assign bus.cpu_rsp_rd_data  = (state == RESP) ? rsp_data : 32'h0;
  assign bus.cpu_rsp_err      = (state == RESP) & rsp_err;
  assign bus.io_bus_s_rd_en   = (state == ISSUE) & ~lat_wr;
  assign bus.io_bus_s_wr_en   = (state == ISSUE) & lat_wr;
  assign bus.io_bus_s_address = (state == ISSUE) ? lat_addr : 32'h0;
  assign bus.io_bus_s_wr_data = (state == ISSUE) ? lat_wdata : 32'h0;
endmodule

// File: tb/tb_io_interconnect.sv
// tb/tb_io_interconnect.sv - directed self-checking bench for io_interconnect
module tb_io_interconnect;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  io_interconnect_if #(.NUM_SLAVES(4)) bus ();

  io_interconnect #(.NUM_SLAVES(4), .TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_req_valid     = 1'b0;
    bus.cpu_req_wr        = 1'b0;
    bus.cpu_req_addr      = 32'h0;
    bus.cpu_req_wr_data   = 32'h0;
    bus.io_bus_s_rd_data  = '0;
    bus.io_bus_s_rd_valid = '0;
  endtask

  task automatic send_req(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    bus.cpu_req_valid   = 1'b1;
    bus.cpu_req_wr      = wr;
    bus.cpu_req_addr    = addr;
    bus.cpu_req_wr_data = data;
    tick();
    bus.cpu_req_valid   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    checks++;
    if (bus.cpu_req_ready !== 1'b1 || bus.cpu_rsp_valid !== 1'b0 || bus.cpu_rsp_rd_data !== 32'h0 ||
        bus.cpu_rsp_err !== 1'b0 || bus.io_bus_s_rd_en !== 1'b0 || bus.io_bus_s_wr_en !== 1'b0 ||
        bus.io_bus_s_address !== 32'h0 || bus.io_bus_s_wr_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_state got ready=%b rsp_valid=%b data=%h err=%b rd_en=%b wr_en=%b addr=%h wdata=%h exp ready=1 rest=0",
               bus.cpu_req_ready, bus.cpu_rsp_valid, bus.cpu_rsp_rd_data, bus.cpu_rsp_err,
               bus.io_bus_s_rd_en, bus.io_bus_s_wr_en, bus.io_bus_s_address, bus.io_bus_s_wr_data);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write(input logic [31:0] addr, input logic [31:0] data);
    send_req(1'b1, addr, data);
    checks++;
    if (bus.io_bus_s_wr_en !== 1'b1 || bus.io_bus_s_rd_en !== 1'b0 || bus.io_bus_s_address !== addr ||
        bus.io_bus_s_wr_data !== data || bus.cpu_req_ready !== 1'b0 || bus.cpu_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL write_issue got wr_en=%b rd_en=%b addr=%h wdata=%h ready=%b rsp_valid=%b exp 1 0 %h %h 0 0",
               bus.io_bus_s_wr_en, bus.io_bus_s_rd_en, bus.io_bus_s_address, bus.io_bus_s_wr_data,
               bus.cpu_req_ready, bus.cpu_rsp_valid, addr, data);
    end
    tick();
    checks++;
    if (bus.cpu_rsp_valid !== 1'b1 || bus.cpu_rsp_err !== 1'b0 || bus.cpu_rsp_rd_data !== 32'h0 ||
        bus.cpu_req_ready !== 1'b0 || bus.io_bus_s_wr_en !== 1'b0 || bus.io_bus_s_address !== 32'h0) begin
      failures++;
      $display("FAIL write_resp got rsp_valid=%b err=%b data=%h ready=%b wr_en=%b addr=%h exp 1 0 0 0 0 0",
               bus.cpu_rsp_valid, bus.cpu_rsp_err, bus.cpu_rsp_rd_data, bus.cpu_req_ready,
               bus.io_bus_s_wr_en, bus.io_bus_s_address);
    end
    tick();
    checks++;
    if (bus.cpu_rsp_valid !== 1'b0 || bus.cpu_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL write_done got rsp_valid=%b ready=%b exp 0 1", bus.cpu_rsp_valid, bus.cpu_req_ready);
    end
  endtask

  task automatic test_read_same_cycle();
    send_req(1'b0, 32'h8000_0800, 32'h0);
    checks++;
    if (bus.io_bus_s_rd_en !== 1'b1 || bus.io_bus_s_wr_en !== 1'b0 || bus.io_bus_s_address !== 32'h8000_0800) begin
      failures++;
      $display("FAIL read_issue got rd_en=%b wr_en=%b addr=%h exp 1 0 80000800",
               bus.io_bus_s_rd_en, bus.io_bus_s_wr_en, bus.io_bus_s_address);
    end
    bus.io_bus_s_rd_valid = 4'b0100;
    bus.io_bus_s_rd_data[64 +: 32] = 32'hCAFE_0001;
    tick();
    idle_inputs();
    checks++;
    if (bus.cpu_rsp_valid !== 1'b1 || bus.cpu_rsp_rd_data !== 32'hCAFE_0001 || bus.cpu_rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL read_same_cycle got valid=%b data=%h err=%b exp 1 cafe0001 0",
               bus.cpu_rsp_valid, bus.cpu_rsp_rd_data, bus.cpu_rsp_err);
    end
    tick();
  endtask

  task automatic test_read_delayed();
    int bad = 0;
    send_req(1'b0, 32'h8000_0000, 32'h0);
    checks++;
    if (bus.io_bus_s_rd_en !== 1'b1) begin
      failures++;
      $display("FAIL delayed_issue got rd_en=%b exp 1", bus.io_bus_s_rd_en);
    end
    for (int c = 2; c <= 4; c++) begin
      tick();
      if (bus.io_bus_s_rd_en !== 1'b0 || bus.io_bus_s_address !== 32'h0 || bus.cpu_rsp_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL delayed_wait got bad_cycles=%0d exp 0", bad);
    end
    bus.io_bus_s_rd_valid = 4'b0001;
    bus.io_bus_s_rd_data[0 +: 32] = 32'h0000_1234;
    tick();
    idle_inputs();
    checks++;
    if (bus.cpu_rsp_valid !== 1'b1 || bus.cpu_rsp_rd_data !== 32'h0000_1234 || bus.cpu_rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL delayed_resp got valid=%b data=%h err=%b exp 1 00001234 0",
               bus.cpu_rsp_valid, bus.cpu_rsp_rd_data, bus.cpu_rsp_err);
    end
    tick();
  endtask

  task automatic test_timeout();
    int early = 0;
    send_req(1'b0, 32'h8000_0C00, 32'h0);
    for (int c = 1; c <= 16; c++) begin
      if (bus.cpu_rsp_valid !== 1'b0) early++;
      if (c < 16) tick();
    end
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL timeout_early got early_rsp=%0d exp 0", early);
    end
    tick();
    checks++;
    if (bus.cpu_rsp_valid !== 1'b1 || bus.cpu_rsp_err !== 1'b1 || bus.cpu_rsp_rd_data !== 32'h0) begin
      failures++;
      $display("FAIL timeout_resp got valid=%b err=%b data=%h exp 1 1 0",
               bus.cpu_rsp_valid, bus.cpu_rsp_err, bus.cpu_rsp_rd_data);
    end
    tick();
    bus.io_bus_s_rd_valid = 4'b1000;
    bus.io_bus_s_rd_data[96 +: 32] = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    checks++;
    if (bus.cpu_rsp_valid !== 1'b0 || bus.cpu_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL stray_valid got rsp_valid=%b ready=%b exp 0 1", bus.cpu_rsp_valid, bus.cpu_req_ready);
    end
  endtask

  task automatic test_overlap();
    send_req(1'b0, 32'h8000_0400, 32'h0);
    bus.io_bus_s_rd_valid = 4'b0011;
    bus.io_bus_s_rd_data[0 +: 32]  = 32'h0000_00F0;
    bus.io_bus_s_rd_data[32 +: 32] = 32'h0000_0F00;
    bus.io_bus_s_rd_data[64 +: 32] = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    checks++;
    if (bus.cpu_rsp_valid !== 1'b1 || bus.cpu_rsp_rd_data !== 32'h0000_0FF0 || bus.cpu_rsp_err !== 1'b1) begin
      failures++;
      $display("FAIL overlap got valid=%b data=%h err=%b exp 1 00000ff0 1",
               bus.cpu_rsp_valid, bus.cpu_rsp_rd_data, bus.cpu_rsp_err);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.cpu_req_valid   = 1'b1;
    bus.cpu_req_wr      = 1'b1;
    bus.cpu_req_addr    = 32'h8000_0010;
    bus.cpu_req_wr_data = 32'h0000_0011;
    tick();
    bus.cpu_req_addr    = 32'h8000_0020;
    bus.cpu_req_wr_data = 32'h0000_0022;
    checks++;
    if (bus.io_bus_s_wr_en !== 1'b1 || bus.io_bus_s_address !== 32'h8000_0010) begin
      failures++;
      $display("FAIL b2b_first got wr_en=%b addr=%h exp 1 80000010", bus.io_bus_s_wr_en, bus.io_bus_s_address);
    end
    tick();
    tick();
    checks++;
    if (bus.cpu_req_ready !== 1'b1 || bus.io_bus_s_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL b2b_gap got ready=%b wr_en=%b exp 1 0", bus.cpu_req_ready, bus.io_bus_s_wr_en);
    end
    tick();
    bus.cpu_req_valid = 1'b0;
    checks++;
    if (bus.io_bus_s_wr_en !== 1'b1 || bus.io_bus_s_address !== 32'h8000_0020 || bus.io_bus_s_wr_data !== 32'h0000_0022) begin
      failures++;
      $display("FAIL b2b_second got wr_en=%b addr=%h wdata=%h exp 1 80000020 00000022",
               bus.io_bus_s_wr_en, bus.io_bus_s_address, bus.io_bus_s_wr_data);
    end
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    int late = 0;
    send_req(1'b0, 32'h8000_0C00, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.cpu_req_ready !== 1'b1 || bus.cpu_rsp_valid !== 1'b0 || bus.io_bus_s_rd_en !== 1'b0 ||
        bus.io_bus_s_wr_en !== 1'b0 || bus.io_bus_s_address !== 32'h0 || bus.cpu_rsp_rd_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid got ready=%b rsp_valid=%b rd_en=%b wr_en=%b addr=%h data=%h exp 1 0 0 0 0 0",
               bus.cpu_req_ready, bus.cpu_rsp_valid, bus.io_bus_s_rd_en, bus.io_bus_s_wr_en,
               bus.io_bus_s_address, bus.cpu_rsp_rd_data);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.cpu_rsp_valid !== 1'b0) late++;
    end
    checks++;
    if (late != 0) begin
      failures++;
      $display("FAIL reset_no_rsp got rsp_cycles=%0d exp 0", late);
    end
    test_write(32'h8000_0400, 32'h0000_0007);
  endtask

  initial begin
    test_reset();
    test_write(32'h8000_0400, 32'h0000_0005);
    test_read_same_cycle();
    test_read_delayed();
    test_timeout();
    test_overlap();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
